fuzz_program_gen: RTL
=====================

Name: fuzz_program_gen

Overview:
- Synthesizable transmitter for the fuzz instruction stream: from a seed it generates a pseudo-random program of 32-bit instruction words and terminates it with HALT.
- Words go out over a valid/ready interface, so the stream can be loaded into instruction memory, written to fuzz_program.hex through a bench sink, or fed to a core.
- Also predicts the μ-discovery total the executor will report, so a host can cross-check the executor without re-simulating.

Parameters:
- MAX_INSTRUCTIONS, 256, instruction-memory depth; the HALT index never exceeds MAX_INSTRUCTIONS-1.
- LFSR_POLY, 32'h80200003, Galois feedback taps (x^32+x^22+x^2+x+1).
- REGION_MAX, 63, highest PNEW region index; regions span 0..63.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy=1.
- seed  in  32  LFSR seed, sampled on accepted start.
- prog_len  in  8  number of random words before HALT, sampled on accepted start.
- instr_valid  out  1  instr_data is valid.
- instr_ready  in  1  sink accepts the word on a cycle where instr_valid && instr_ready.
- instr_data  out  32  {opcode[31:24], a[23:16], b[15:8], 8'h00}.
- instr_index  out  8  slot number of instr_data, 0..prog_len.
- busy  out  1  stream in progress.
- done  out  1  level; set after HALT is accepted, cleared on the next accepted start.
- mu_pred  out  7  predicted μ-discovery count; valid when done=1.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; LFSR=1; seen mask=64'h1.
- Reset asserted mid-stream aborts immediately; no HALT is emitted.
- FSM states:
  - IDLE: on start, load LFSR (seed==0 loads 32'h1), latch len=min(prog_len, MAX_INSTRUCTIONS-1), clear index, seen=64'h1, mu_pred=0, done=0, busy=1.
  - Next state is GEN if len>0, else HALT_W.
  - instr_valid rises the cycle after start is accepted.
  - GEN: present the random word built from the current LFSR state s.
    - On handshake: advance the LFSR once, index++.
    - When the accepted index equals len-1, go to HALT_W.
  - HALT_W: present {OPCODE_HALT, 24'h0} at index=len. On handshake: instr_valid=0, busy=0, done=1, go to IDLE.
- Handshake rules:
  - instr_valid stays high and instr_data/instr_index stay stable until accepted.
  - Back-to-back acceptance gives one word per cycle.
  - instr_ready while instr_valid=0 is ignored.
- Opcode select from sel=s[2:0]:
  - 0,5 → PNEW
  - 1,6 → XOR_LOAD
  - 2,7 → XOR_ADD
  - 3 → XOR_SWAP
  - 4 → EMIT
- Operands per opcode:
  - PNEW: a={2'b0, s[13:8]}, b=8'h00.
  - XOR_LOAD: a={3'b0, s[12:8]}, b=s[23:16].
  - XOR_ADD/XOR_SWAP: a={3'b0, s[12:8]}, b={3'b0, s[20:16]}.
  - EMIT: a=s[15:8], b=s[23:16].
- Nonzero guarantee: any random word that would equal 32'h0 has b forced to 8'h01. The executor treats zero words as end of program.
- LFSR step: s_next = s[0] ? (s>>1)^LFSR_POLY : s>>1.
- μ prediction, on each accepted PNEW with region r:
  - if seen[r]=0, set seen[r]=1 and mu_pred++;
  - region 0 is pre-seen (genesis module).
  - Maximum mu_pred is 63, so no overflow.
- start while busy is dropped silently; start in the same cycle as the HALT handshake is also dropped.

Decomposition:
- Shared package thiele_fuzz_pkg holds:
  - opcode constants, sourced from generated_opcodes.vh;
  - instruction field offsets;
  - LFSR_POLY default;
  - the HALT word constant.
- One sub-module, fuzz_lfsr32: load, advance, 32-bit state output.

Test Plan:
- seed=0, prog_len=0, ready=1 → one word {OPCODE_HALT,24'h0} at index 0; done=1 and mu_pred=0 the cycle after; busy=0.
- seed=0, prog_len=1 → word 0 = {OPCODE_XOR_LOAD,8'h00,8'h00,8'h00} (LFSR state 1); word 1 = HALT at index 1.
- seed=32'hDEADBEEF, prog_len=8, instr_ready low 5 cycles at word 3 → instr_data/instr_index held 5 cycles; 9 words total; index sequence 0..8 with no gaps.
- seed=1, prog_len=255, ready randomized, bench model of LFSR and dedupe:
  - all 256 words match the model; no word equals 0;
  - mu_pred equals the model count and is ≤63.
- rst_n pulled low during word 4 → instr_valid, busy, done, mu_pred read 0 immediately; a following start with the same seed reproduces the identical stream.
- start pulsed while busy and on the HALT handshake cycle → ignored; the stream is unchanged, and only one done assertion occurs.

Source files
------------

// File: rtl/thiele_fuzz_pkg.sv
// Shared definitions for the fuzz instruction stream: opcodes, field layout,
// LFSR default polynomial, HALT word and the random-word builder.
package thiele_fuzz_pkg;

   // Opcode values mirror generated_opcodes.vh so the executor and generator agree.
   localparam logic [7:0] OPCODE_PNEW     = 8'h00;
   localparam logic [7:0] OPCODE_XOR_LOAD = 8'h0A;
   localparam logic [7:0] OPCODE_XOR_ADD  = 8'h0B;
   localparam logic [7:0] OPCODE_XOR_SWAP = 8'h0C;
   localparam logic [7:0] OPCODE_EMIT     = 8'h0E;
   localparam logic [7:0] OPCODE_HALT     = 8'hFF;

   // Instruction word layout: {opcode, a, b, 8'h00}.
   localparam int OP_LSB = 24;
   localparam int A_LSB  = 16;
   localparam int B_LSB  = 8;

   localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] HALT_WORD         = {OPCODE_HALT, 24'h0};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GEN    = 2'd1,
      ST_HALT_W = 2'd2
   } fsm_state_t;

   // True when the word built from LFSR state s is a PNEW.
   function automatic logic is_pnew(input logic [2:0] sel);
      return (sel == 3'd0) || (sel == 3'd5);
   endfunction

   // Build the random instruction word for LFSR state s.
   function automatic logic [31:0] build_word(input logic [31:0] s);
      logic [7:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [31:0] w;
      op = OPCODE_PNEW;
      a  = 8'h00;
      b  = 8'h00;
      case (s[2:0])
         3'd0, 3'd5: begin
            op = OPCODE_PNEW;
            a  = {2'b0, s[13:8]};
            b  = 8'h00;
         end
         3'd1, 3'd6: begin
            op = OPCODE_XOR_LOAD;
            a  = {3'b0, s[12:8]};
            b  = s[23:16];
         end
         3'd2, 3'd7: begin
            op = OPCODE_XOR_ADD;
            a  = {3'b0, s[12:8]};
            b  = {3'b0, s[20:16]};
         end
         3'd3: begin
            op = OPCODE_XOR_SWAP;
            a  = {3'b0, s[12:8]};
            b  = {3'b0, s[20:16]};
         end
         default: begin
            op = OPCODE_EMIT;
            a  = s[15:8];
            b  = s[23:16];
         end
      endcase
      w = {op, a, b, 8'h00};
      // The executor stops on an all-zero word, so never emit one mid-program.
      if (w == 32'h0) begin
         w[B_LSB +: 8] = 8'h01;
      end
      return w;
   endfunction

endpackage

// File: rtl/fuzz_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
module fuzz_lfsr32
   import thiele_fuzz_pkg::*;
#(
   parameter logic [31:0] POLY = DEFAULT_LFSR_POLY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        advance,
   output logic [31:0] state
);

   logic [31:0] step_value;

   // One Galois step: shift right, fold taps in when the outgoing bit is 1.
   always_comb begin
      step_value = state[0] ? ((state >> 1) ^ POLY) : (state >> 1);
   end

   // State register; load has priority over advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= 32'h1;
      end else if (load) begin
         state <= load_value;
      end else if (advance) begin
         state <= step_value;
      end
   end

endmodule

// File: rtl/fuzz_program_gen.sv
// Streams a seeded pseudo-random program terminated by HALT and predicts the
// number of distinct PNEW regions (mu-discovery count) the executor will see.
//
// Handshake: a word transfers on a cycle where instr_valid && instr_ready at the
// rising clock edge; while instr_valid is high, instr_data/instr_index hold
// steady until that transfer, and instr_ready is ignored when instr_valid is low.
module fuzz_program_gen
   import thiele_fuzz_pkg::*;
#(
   parameter int          MAX_INSTRUCTIONS = 256,
   parameter logic [31:0] LFSR_POLY        = DEFAULT_LFSR_POLY,
   parameter int          REGION_MAX       = 63
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] seed,
   input  logic [7:0]  prog_len,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [7:0]  instr_index,
   output logic        busy,
   output logic        done,
   output logic [6:0]  mu_pred
);

   localparam logic [7:0] LEN_CAP = 8'(MAX_INSTRUCTIONS - 1);

   fsm_state_t          state;
   fsm_state_t          state_next;
   logic [7:0]          len;
   logic [7:0]          index;
   logic [REGION_MAX:0] seen;
   logic [31:0]         lfsr_state;
   logic [31:0]         lfsr_load_value;
   logic [7:0]          len_in;
   logic [5:0]          region;
   logic                start_accept;
   logic                accept;
   logic                gen_accept;
   logic                halt_accept;
   logic                new_region;

   // Handshake qualifiers and start/length sampling.
   always_comb begin
      start_accept    = (state == ST_IDLE) && start;
      accept          = instr_valid && instr_ready;
      gen_accept      = (state == ST_GEN) && accept;
      halt_accept     = (state == ST_HALT_W) && accept;
      len_in          = (prog_len > LEN_CAP) ? LEN_CAP : prog_len;
      lfsr_load_value = (seed == 32'h0) ? 32'h1 : seed;
      region          = lfsr_state[13:8];
      new_region      = gen_accept && is_pnew(lfsr_state[2:0]) && !seen[region];
   end

   fuzz_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (start_accept),
      .load_value (lfsr_load_value),
      .advance    (gen_accept),
      .state      (lfsr_state)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and stream outputs.
   always_comb begin
      state_next  = state;
      instr_valid = 1'b0;
      instr_data  = 32'h0;
      instr_index = 8'h0;
      busy        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (len_in != 8'h0) ? ST_GEN : ST_HALT_W;
            end
         end
         ST_GEN: begin
            instr_valid = 1'b1;
            instr_data  = build_word(lfsr_state);
            instr_index = index;
            busy        = 1'b1;
            if (accept && (index == len - 8'd1)) begin
               state_next = ST_HALT_W;
            end
         end
         ST_HALT_W: begin
            instr_valid = 1'b1;
            instr_data  = HALT_WORD;
            instr_index = index;
            busy        = 1'b1;
            if (accept) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Length, slot index, region-seen mask, mu prediction and done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len     <= 8'h0;
         index   <= 8'h0;
         seen    <= {{REGION_MAX{1'b0}}, 1'b1};
         mu_pred <= 7'h0;
         done    <= 1'b0;
      end else if (start_accept) begin
         len     <= len_in;
         index   <= 8'h0;
         seen    <= {{REGION_MAX{1'b0}}, 1'b1};
         mu_pred <= 7'h0;
         done    <= 1'b0;
      end else begin
         if (gen_accept) begin
            index <= index + 8'd1;
         end
         if (new_region) begin
            seen[region] <= 1'b1;
            mu_pred      <= mu_pred + 7'd1;
         end
         if (halt_accept) begin
            done <= 1'b1;
         end
      end
   end

endmodule
